// File: rtl/class_score_scheduler.sv
// class_score_scheduler: per-word naive-Bayes scoring sequencer.
// Time-multiplexes one log-likelihood table read port across all classes,
// keeps a saturating signed score per class and runs a sequential argmax
// at end of message.
module class_score_scheduler #(
  parameter int AMOUNT_CLASS  = 4,
  parameter int WIDTH_FIFO_RX = 8,
  parameter int WIDTH_LOG_W   = 16,
  parameter int WIDTH_LOG_D   = 16,
  parameter int WIDTH_LOG_V   = 16,
  parameter int WIDTH_ACC     = 24
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  enable,
  input  logic [WIDTH_FIFO_RX-1:0]              word,
  input  logic                                  last,
  output logic                                  ready,
  output logic                                  w_rd,
  output logic [WIDTH_FIFO_RX-1:0]              w_addr,
  output logic [$clog2(AMOUNT_CLASS)-1:0]       w_class,
  input  logic [WIDTH_LOG_W-1:0]                w_data,
  input  logic [WIDTH_LOG_D*AMOUNT_CLASS-1:0]   log_D,
  input  logic [WIDTH_LOG_V*AMOUNT_CLASS-1:0]   log_V,
  output logic [$clog2(AMOUNT_CLASS):0]         class_win,
  output logic                                  done,
  output logic                                  overflow
);

  localparam int CW = $clog2(AMOUNT_CLASS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_WORD = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_ARGMAX    = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [CW-1:0] K_LAST = CW'(AMOUNT_CLASS - 1);

  logic [2:0]                     state;
  logic [CW-1:0]                  k;
  logic [WIDTH_FIFO_RX-1:0]       word_q;
  logic                           word_seen;
  logic                           last_pend;
  logic                           overflow_q;
  logic                           rd_q;
  logic [CW-1:0]                  cls_q;
  logic signed [WIDTH_ACC-1:0]    acc [AMOUNT_CLASS];
  logic signed [WIDTH_ACC-1:0]    best;
  logic [CW-1:0]                  best_idx;
  logic [CW:0]                    win_q;

  logic signed [WIDTH_ACC-1:0]    acc_cur;
  logic [WIDTH_LOG_V-1:0]         logv_cur;
  logic [WIDTH_ACC:0]             sum_ext;
  logic signed [WIDTH_ACC-1:0]    acc_sat;
  logic signed [WIDTH_ACC-1:0]    acc_k;
  logic                           take;
  logic [CW-1:0]                  cand_idx;
  logic                           in_busy;

  // Outputs decoded from state and registers
  always_comb begin
    ready     = (state == S_WAIT_WORD);
    w_rd      = (state == S_ISSUE);
    w_addr    = (state == S_ISSUE) ? word_q : '0;
    w_class   = (state == S_ISSUE) ? k : '0;
    done      = (state == S_DONE);
    overflow  = overflow_q;
    class_win = win_q;
    in_busy   = (state != S_IDLE) && (state != S_WAIT_WORD);
  end

  // Select the accumulator and normaliser for the class whose data returns now
  always_comb begin
    acc_cur  = '0;
    logv_cur = '0;
    for (int unsigned c = 0; c < AMOUNT_CLASS; c++) begin
      if (cls_q == CW'(c)) begin
        acc_cur  = acc[c];
        logv_cur = log_V[c*WIDTH_LOG_V +: WIDTH_LOG_V];
      end
    end
  end

  // One guard bit of headroom, then clamp to the signed accumulator range
  always_comb begin
    sum_ext = {acc_cur[WIDTH_ACC-1], acc_cur}
            + {{(WIDTH_ACC+1-WIDTH_LOG_W){w_data[WIDTH_LOG_W-1]}}, w_data}
            - {{(WIDTH_ACC+1-WIDTH_LOG_V){logv_cur[WIDTH_LOG_V-1]}}, logv_cur};
    if (sum_ext[WIDTH_ACC] != sum_ext[WIDTH_ACC-1]) begin
      acc_sat = sum_ext[WIDTH_ACC] ? {1'b1, {(WIDTH_ACC-1){1'b0}}}
                                   : {1'b0, {(WIDTH_ACC-1){1'b1}}};
    end else begin
      acc_sat = sum_ext[WIDTH_ACC-1:0];
    end
  end

  // Argmax step: first class seeds best, later ones must be strictly greater
  always_comb begin
    acc_k = '0;
    for (int unsigned c = 0; c < AMOUNT_CLASS; c++) begin
      if (k == CW'(c)) acc_k = acc[c];
    end
    take     = (k == '0) || (acc_k > best);
    cand_idx = take ? k : best_idx;
  end

  // Sequencer, score accumulation and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k          <= '0;
      word_q     <= '0;
      word_seen  <= 1'b0;
      last_pend  <= 1'b0;
      overflow_q <= 1'b0;
      rd_q       <= 1'b0;
      cls_q      <= '0;
      best       <= '0;
      best_idx   <= '0;
      win_q      <= '0;
      for (int unsigned c = 0; c < AMOUNT_CLASS; c++) acc[c] <= '0;
    end else if (start) begin
      // Restart discards any read still in flight
      state <= S_LOAD;
      k     <= '0;
      rd_q  <= 1'b0;
    end else begin
      rd_q  <= (state == S_ISSUE);
      cls_q <= k;
      if (rd_q) acc[cls_q] <= acc_sat;

      case (state)
        S_IDLE: ;
        S_LOAD: begin
          for (int unsigned c = 0; c < AMOUNT_CLASS; c++) begin
            acc[c] <= {{(WIDTH_ACC-WIDTH_LOG_D){log_D[c*WIDTH_LOG_D+WIDTH_LOG_D-1]}},
                       log_D[c*WIDTH_LOG_D +: WIDTH_LOG_D]};
          end
          word_seen  <= 1'b0;
          last_pend  <= 1'b0;
          overflow_q <= 1'b0;
          state      <= S_WAIT_WORD;
        end
        S_WAIT_WORD: begin
          if (enable) begin
            word_q    <= word;
            word_seen <= 1'b1;
            k         <= '0;
            state     <= S_ISSUE;
            if (last) last_pend <= 1'b1;
          end else if (last || last_pend) begin
            k     <= '0;
            state <= S_ARGMAX;
          end
        end
        S_ISSUE: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: state <= S_WAIT_WORD;
        S_ARGMAX: begin
          if (take) begin
            best     <= acc_k;
            best_idx <= k;
          end
          if (k == K_LAST) begin
            win_q <= word_seen ? {1'b0, cand_idx} : {1'b1, {CW{1'b0}}};
            k     <= '0;
            state <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Placed after the case so a late last/enable wins over the LOAD clear
      if (last && in_busy)   last_pend  <= 1'b1;
      if (enable && in_busy) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_class_score_scheduler.sv
// Scoreboard bench for class_score_scheduler: stimulus pushes expected
// class_win values, a monitor pops and compares on every done pulse.
module tb_class_score_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, enable = 1'b0, last = 1'b0, sat_sel = 1'b0;
  logic [7:0]  word = '0;
  logic [63:0] log_D = '0, log_V = '0;

  logic        m_start, m_enable, m_last, s_start, s_enable, s_last;
  logic        m_ready, m_w_rd, m_done, m_overflow;
  logic        s_ready, s_w_rd, s_done, s_overflow;
  logic [7:0]  m_w_addr, s_w_addr;
  logic [1:0]  m_w_class, s_w_class;
  logic [15:0] m_w_data, s_w_data;
  logic [2:0]  m_class_win, s_class_win;
  logic        c_ready, c_w_rd, c_done, c_overflow;
  logic [1:0]  c_w_class;

  assign m_start  = start  & ~sat_sel;
  assign m_enable = enable & ~sat_sel;
  assign m_last   = last   & ~sat_sel;
  assign s_start  = start  &  sat_sel;
  assign s_enable = enable &  sat_sel;
  assign s_last   = last   &  sat_sel;

  assign c_ready    = sat_sel ? s_ready    : m_ready;
  assign c_w_rd     = sat_sel ? s_w_rd     : m_w_rd;
  assign c_done     = sat_sel ? s_done     : m_done;
  assign c_overflow = sat_sel ? s_overflow : m_overflow;
  assign c_w_class  = sat_sel ? s_w_class  : m_w_class;

  class_score_scheduler #(
    .AMOUNT_CLASS(4), .WIDTH_FIFO_RX(8), .WIDTH_LOG_W(16),
    .WIDTH_LOG_D(16), .WIDTH_LOG_V(16), .WIDTH_ACC(24)
  ) dut (
    .clk(clk), .rst(rst), .start(m_start), .enable(m_enable), .word(word),
    .last(m_last), .ready(m_ready), .w_rd(m_w_rd), .w_addr(m_w_addr),
    .w_class(m_w_class), .w_data(m_w_data), .log_D(log_D), .log_V(log_V),
    .class_win(m_class_win), .done(m_done), .overflow(m_overflow)
  );

  class_score_scheduler #(
    .AMOUNT_CLASS(4), .WIDTH_FIFO_RX(8), .WIDTH_LOG_W(16),
    .WIDTH_LOG_D(16), .WIDTH_LOG_V(16), .WIDTH_ACC(17)
  ) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .enable(s_enable), .word(word),
    .last(s_last), .ready(s_ready), .w_rd(s_w_rd), .w_addr(s_w_addr),
    .w_class(s_w_class), .w_data(s_w_data), .log_D(log_D), .log_V(log_V),
    .class_win(s_class_win), .done(s_done), .overflow(s_overflow)
  );

  // Log-likelihood table model with one cycle of read latency
  logic signed [15:0] tbl [4][256];
  always @(posedge clk) begin
    m_w_data <= tbl[m_w_class][m_w_addr];
    s_w_data <= tbl[s_w_class][s_w_addr];
  end

  int total = 0;
  int bad   = 0;
  logic [2:0] sb [$];
  logic [2:0] exp_w;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected winner
  initial begin
    forever begin
      @(negedge clk);
      if (m_done || s_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: class_win=%0d with nothing expected",
                   m_done ? m_class_win : s_class_win);
        end else begin
          exp_w = sb.pop_front();
          chk("class_win", int'(m_done ? m_class_win : s_class_win), int'(exp_w));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pv(input int d0, d1, d2, d3, v0, v1, v2, v3);
    log_D = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    log_V = {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endtask

  task automatic set_tbl(input int w, input int t0, t1, t2, t3);
    tbl[0][w] = 16'(t0);
    tbl[1][w] = 16'(t1);
    tbl[2][w] = 16'(t2);
    tbl[3][w] = 16'(t3);
  endtask

  task automatic begin_msg;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("load_ready", int'(c_ready), 0);
    tick;
    chk("start_ready_t2", int'(c_ready), 1);
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!c_ready && n < 40) begin
      tick;
      n++;
    end
    if (!c_ready) begin
      total++;
      bad++;
      $display("FAIL wait_ready: ready=0 required=1 after 40 cycles");
    end
  endtask

  task automatic send_word(input int w);
    wait_ready;
    enable = 1'b1;
    word   = 8'(w);
    tick;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("issue_rd", int'(c_w_rd), 1);
      chk("issue_class", int'(c_w_class), i);
      tick;
    end
    chk("drain_rd", int'(c_w_rd), 0);
    tick;
    chk("ready_after_drain", int'(c_ready), 1);
  endtask

  task automatic send_last(input logic [2:0] exp, input int lat);
    int n;
    sb.push_back(exp);
    wait_ready;
    last = 1'b1;
    tick;
    last = 1'b0;
    n = 1;
    while (!c_done && n < 40) begin
      tick;
      n++;
    end
    chk("done_latency", n, lat);
    tick;
  endtask

  initial begin
    int seen;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 256; w++) tbl[c][w] = '0;

    // Reset state
    repeat (2) tick;
    rst = 1'b0;
    chk("rst_ready", int'(m_ready), 0);
    chk("rst_w_rd", int'(m_w_rd), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_class_win", int'(m_class_win), 0);

    // Basic winner
    set_pv(0, 0, 0, 0, 0, 0, 0, 0);
    set_tbl(5, 10, 2, 3, 4);
    begin_msg;
    send_word(5);
    send_last(3'b000, 5);

    // Prior plus normaliser: scores {4,3,-1,1}
    set_pv(5, 3, 8, 1, 1, 0, 9, 0);
    begin_msg;
    send_word(1);
    chk("score0", int'(dut.acc[0]), 4);
    chk("score1", int'(dut.acc[1]), 3);
    chk("score2", int'(dut.acc[2]), -1);
    chk("score3", int'(dut.acc[3]), 1);
    send_last(3'b000, 5);

    // Tie on priors resolves to lowest index
    set_pv(7, 7, 2, 2, 0, 0, 0, 0);
    begin_msg;
    send_word(2);
    send_last(3'b000, 5);

    // Tie between classes 1 and 2 via table
    set_pv(0, 0, 0, 0, 0, 0, 0, 0);
    set_tbl(9, 1, 5, 5, 2);
    begin_msg;
    send_word(9);
    send_last(3'b001, 5);

    // No data
    begin_msg;
    send_last(3'b100, 5);

    // Overflow, then enable+last together
    set_tbl(4, 0, 0, 0, 9);
    set_tbl(6, 0, 0, 20, 0);
    set_tbl(7, 100, 0, 0, 0);
    begin_msg;
    chk("ovf_clear_initial", int'(m_overflow), 0);
    wait_ready;
    enable = 1'b1;
    word   = 8'd4;
    tick;
    enable = 1'b0;
    tick;
    enable = 1'b1;
    word   = 8'd7;
    tick;
    enable = 1'b0;
    chk("overflow_set", int'(m_overflow), 1);
    wait_ready;
    sb.push_back(3'b010);
    enable = 1'b1;
    word   = 8'd6;
    last   = 1'b1;
    tick;
    enable = 1'b0;
    last   = 1'b0;
    seen = 1;
    while (!m_done && seen < 40) begin
      tick;
      seen++;
    end
    chk("done_after_drain", seen, 11);
    tick;
    chk("overflow_sticky", int'(m_overflow), 1);

    // Restart during third ISSUE cycle
    set_pv(1, 2, 3, 4, 0, 0, 0, 0);
    begin_msg;
    chk("overflow_cleared", int'(m_overflow), 0);
    wait_ready;
    enable = 1'b1;
    word   = 8'd5;
    tick;
    enable = 1'b0;
    tick;
    tick;
    chk("third_issue_class", int'(m_w_class), 2);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart_load_ready", int'(m_ready), 0);
    chk("restart_load_rd", int'(m_w_rd), 0);
    tick;
    chk("restart_ready", int'(m_ready), 1);
    for (int c = 0; c < 4; c++) chk("restart_score", int'(dut.acc[c]), c + 1);
    seen = 0;
    repeat (12) begin
      tick;
      if (m_done) seen = 1;
    end
    chk("restart_no_done", seen, 0);

    // Saturation on the 17-bit accumulator instance
    sat_sel = 1'b1;
    set_pv(0, 0, 0, 0, 0, 0, 0, 0);
    set_tbl(3, 10000, 0, 32767, 0);
    begin_msg;
    repeat (5) send_word(3);
    chk("sat_acc2", int'(dut_s.acc[2]), 65535);
    chk("sat_acc0", int'(dut_s.acc[0]), 50000);
    send_last(3'b010, 5);
    sat_sel = 1'b0;

    // Reset during ARGMAX
    begin_msg;
    send_word(5);
    wait_ready;
    last = 1'b1;
    tick;
    last = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("argrst_ready", int'(m_ready), 0);
    chk("argrst_w_rd", int'(m_w_rd), 0);
    chk("argrst_done", int'(m_done), 0);
    chk("argrst_overflow", int'(m_overflow), 0);
    chk("argrst_w_addr", int'(m_w_addr), 0);
    chk("argrst_w_class", int'(m_w_class), 0);
    chk("argrst_class_win", int'(m_class_win), 0);
    chk("argrst_acc0", int'(dut.acc[0]), 0);
    repeat (8) tick;
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
